// File: rtl/fir_error_monitor_if.sv
// Handshake and statistics bundle between a sample producer and fir_error_monitor.
// With FIR_ERRMON_SQERR_EN defined the bundle also carries err_sq_sum.
interface fir_error_monitor_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] approx_in;
  logic [WIDTH-1:0] exact_in;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] err_sum;
  logic [WIDTH-1:0] err_max;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] sample_cnt;
`ifdef FIR_ERRMON_SQERR_EN
  logic [2*WIDTH+ACC_W-1:0] err_sq_sum;

  modport master (
    output start, in_valid, approx_in, exact_in,
    input  in_ready, busy, done, err_sum, err_max, mismatch_cnt, sample_cnt, err_sq_sum
  );
  modport slave (
    input  start, in_valid, approx_in, exact_in,
    output in_ready, busy, done, err_sum, err_max, mismatch_cnt, sample_cnt, err_sq_sum
  );
`else
  modport master (
    output start, in_valid, approx_in, exact_in,
    input  in_ready, busy, done, err_sum, err_max, mismatch_cnt, sample_cnt
  );
  modport slave (
    input  start, in_valid, approx_in, exact_in,
    output in_ready, busy, done, err_sum, err_max, mismatch_cnt, sample_cnt
  );
`endif
endinterface

// File: rtl/fir_error_monitor.sv
// Windowed error statistics between approximate and exact FIR outputs.
// Optional squared-error accumulator enabled by defining FIR_ERRMON_SQERR_EN.
module fir_error_monitor #(
  parameter int WIDTH   = 16,
  parameter int WIN_LEN = 256,
  parameter int ACC_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fir_error_monitor_if.slave    bus
);
  localparam int SW = ACC_W + WIDTH;
  localparam logic [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             drain_cnt_q;

  logic             s1_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             neq_q;

  logic [ACC_W-1:0] err_sum_q;
  logic [WIDTH-1:0] err_max_q;
  logic [CNT_W-1:0] mismatch_cnt_q;
  logic [CNT_W-1:0] sample_cnt_q;

  logic             accept;
  logic             last_accept;
  logic [WIDTH:0]   diff_wide;
  logic [WIDTH:0]   diff_neg;
  logic [WIDTH-1:0] abs_diff_d;
  logic [SW-1:0]    sum_wide;
  logic [ACC_W-1:0] err_sum_d;
  logic [WIDTH-1:0] err_max_d;

  assign accept      = bus.in_valid & in_ready_q;
  assign last_accept = accept && (sample_cnt_q == LAST_IDX);

  // One extra bit keeps the sign of approx-exact so the magnitude is exact.
  assign diff_wide  = {1'b0, bus.approx_in} - {1'b0, bus.exact_in};
  assign diff_neg   = -diff_wide;
  assign abs_diff_d = diff_wide[WIDTH] ? diff_neg[WIDTH-1:0] : diff_wide[WIDTH-1:0];

  assign sum_wide  = SW'(err_sum_q) + SW'(diff_q);
  assign err_sum_d = (sum_wide > ACC_MAX) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  assign err_max_d = (diff_q > err_max_q) ? diff_q : err_max_q;

`ifdef FIR_ERRMON_SQERR_EN
  localparam int SQ_W = ACC_W + 2 * WIDTH;
  logic [SQ_W-1:0]    err_sq_q;
  logic [2*WIDTH-1:0] diff_sq;
  logic [SQ_W:0]      sq_wide;
  logic [SQ_W-1:0]    err_sq_d;

  assign diff_sq  = {{WIDTH{1'b0}}, diff_q} * {{WIDTH{1'b0}}, diff_q};
  assign sq_wide  = {1'b0, err_sq_q} + (SQ_W+1)'(diff_sq);
  assign err_sq_d = sq_wide[SQ_W] ? {SQ_W{1'b1}} : sq_wide[SQ_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sq_q <= '0;
    end else if (bus.start && (state_q == S_IDLE || state_q == S_DONE)) begin
      err_sq_q <= '0;
    end else if (s1_valid_q) begin
      err_sq_q <= err_sq_d;
    end
  end

  assign bus.err_sq_sum = err_sq_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      drain_cnt_q    <= 1'b0;
      s1_valid_q     <= 1'b0;
      diff_q         <= '0;
      neq_q          <= 1'b0;
      err_sum_q      <= '0;
      err_max_q      <= '0;
      mismatch_cnt_q <= '0;
      sample_cnt_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        diff_q <= abs_diff_d;
        neq_q  <= (bus.approx_in != bus.exact_in);
      end

      if (s1_valid_q) begin
        err_sum_q      <= err_sum_d;
        err_max_q      <= err_max_d;
        mismatch_cnt_q <= mismatch_cnt_q + CNT_W'(neq_q);
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q        <= S_RUN;
            in_ready_q     <= 1'b1;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            err_sum_q      <= '0;
            err_max_q      <= '0;
            mismatch_cnt_q <= '0;
            sample_cnt_q   <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            sample_cnt_q <= sample_cnt_q + 1'b1;
          end
          if (last_accept) begin
            state_q     <= S_DRAIN;
            in_ready_q  <= 1'b0;
            drain_cnt_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Two drain cycles let the final sample clear both pipeline stages.
          if (drain_cnt_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err_sum      = err_sum_q;
  assign bus.err_max      = err_max_q;
  assign bus.mismatch_cnt = mismatch_cnt_q;
  assign bus.sample_cnt   = sample_cnt_q;
endmodule

// File: tb/tb_fir_error_monitor.sv
// Self-checking bench for fir_error_monitor: directed windows from a table,
// reset/start corner sequences and random windows against a behavioural model.
module tb_fir_error_monitor;
  localparam int WIDTH   = 16;
  localparam int ACC_W   = 17;
  localparam int CNT_W   = 16;
  localparam int WIN_LEN = 4;
  localparam int SQ_W    = ACC_W + 2 * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_error_monitor_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  fir_error_monitor #(
    .WIDTH(WIDTH), .WIN_LEN(WIN_LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0][15:0] a;
    logic [3:0][15:0] e;
    logic [1:0]       mode;   // 0 back-to-back, 1 valid toggling, 2 start pulsed mid-window
    logic [31:0]      exp_sum;
    logic [15:0]      exp_max;
    logic [15:0]      exp_mis;
  } vec_t;

  vec_t tbl[0:3];

  function automatic vec_t mk(input logic [15:0] a0, e0, a1, e1, a2, e2, a3, e3,
                              input logic [1:0] mode, input logic [31:0] s,
                              input logic [15:0] m, input logic [15:0] mis);
    vec_t v;
    v.a[0] = a0; v.e[0] = e0; v.a[1] = a1; v.e[1] = e1;
    v.a[2] = a2; v.e[2] = e2; v.a[3] = a3; v.e[3] = e3;
    v.mode = mode; v.exp_sum = s; v.exp_max = m; v.exp_mis = mis;
    return v;
  endfunction

  // Reference: plain arithmetic over the whole window, saturating sums.
  function automatic void model(input vec_t v, output longint s, output longint m,
                                output longint mis, output longint sq);
    longint d;
    longint acc_lim;
    longint sq_lim;
    acc_lim = (longint'(1) << ACC_W) - 1;
    sq_lim  = (longint'(1) << SQ_W) - 1;
    s = 0; m = 0; mis = 0; sq = 0;
    for (int k = 0; k < WIN_LEN; k++) begin
      d = longint'(v.a[k]) - longint'(v.e[k]);
      if (d < 0) d = -d;
      s   = (s + d > acc_lim) ? acc_lim : s + d;
      sq  = (sq + d * d > sq_lim) ? sq_lim : sq + d * d;
      m   = (d > m) ? d : m;
      mis = mis + ((d != 0) ? 1 : 0);
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, " busy"}, 64'(bus.busy), 64'd0);
    check({tag, " done"}, 64'(bus.done), 64'd0);
    check({tag, " err_sum"}, 64'(bus.err_sum), 64'd0);
    check({tag, " err_max"}, 64'(bus.err_max), 64'd0);
    check({tag, " mismatch_cnt"}, 64'(bus.mismatch_cnt), 64'd0);
    check({tag, " sample_cnt"}, 64'(bus.sample_cnt), 64'd0);
`ifdef FIR_ERRMON_SQERR_EN
    check({tag, " err_sq_sum"}, 64'(bus.err_sq_sum), 64'd0);
`endif
  endtask

  task automatic check_stats(input string tag, input vec_t v, input longint esq);
    check({tag, " err_sum"}, 64'(bus.err_sum), 64'(v.exp_sum));
    check({tag, " err_max"}, 64'(bus.err_max), 64'(v.exp_max));
    check({tag, " mismatch_cnt"}, 64'(bus.mismatch_cnt), 64'(v.exp_mis));
    check({tag, " sample_cnt"}, 64'(bus.sample_cnt), 64'(WIN_LEN));
`ifdef FIR_ERRMON_SQERR_EN
    check({tag, " err_sq_sum"}, 64'(bus.err_sq_sum), 64'(esq));
`else
    if (esq < 0) $display("unexpected negative model value");
`endif
  endtask

  task automatic run_window(input string tag, input vec_t v);
    longint es, em, emis, esq;
    model(v, es, em, emis, esq);
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    step();
    bus.start = 1'b0;
    check({tag, " start in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, " start busy"}, 64'(bus.busy), 64'd1);
    check({tag, " start done"}, 64'(bus.done), 64'd0);
    check({tag, " start sample_cnt"}, 64'(bus.sample_cnt), 64'd0);
    check({tag, " start err_sum"}, 64'(bus.err_sum), 64'd0);
    check({tag, " start mismatch_cnt"}, 64'(bus.mismatch_cnt), 64'd0);
    for (int k = 0; k < WIN_LEN; k++) begin
      if (v.mode == 2'd1) begin
        bus.in_valid  = 1'b0;
        bus.approx_in = 16'hBEEF;
        bus.exact_in  = 16'h0000;
        step();
      end
      bus.in_valid  = 1'b1;
      bus.approx_in = v.a[k];
      bus.exact_in  = v.e[k];
      if (v.mode == 2'd2 && k == 2) bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check({tag, " accept sample_cnt"}, 64'(bus.sample_cnt), 64'(k + 1));
    end
    // Keep offering junk during drain and done: nothing may be consumed.
    bus.approx_in = 16'hFFFF;
    bus.exact_in  = 16'h0000;
    check({tag, " drain in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, " drain busy"}, 64'(bus.busy), 64'd1);
    check({tag, " drain done"}, 64'(bus.done), 64'd0);
    step();
    check({tag, " drain2 done"}, 64'(bus.done), 64'd0);
    step();
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " done busy"}, 64'(bus.busy), 64'd0);
    check({tag, " done in_ready"}, 64'(bus.in_ready), 64'd0);
    check_stats(tag, v, esq);
    step();
    step();
    check({tag, " held done"}, 64'(bus.done), 64'd1);
    check_stats({tag, " held"}, v, esq);
    bus.in_valid = 1'b0;
    $display("window %s mode=%0d err_sum=%0d err_max=%0d mismatch_cnt=%0d sample_cnt=%0d",
             tag, v.mode, bus.err_sum, bus.err_max, bus.mismatch_cnt, bus.sample_cnt);
  endtask

  initial begin
    vec_t rv;
    longint es, em, emis, esq;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.approx_in = '0;
    bus.exact_in  = '0;

    tbl[0] = mk(10, 10, 12, 10, 5, 9, 0, 0, 2'd0, 6, 4, 2);
    tbl[1] = mk(10, 10, 12, 10, 5, 9, 0, 0, 2'd1, 6, 4, 2);
    tbl[2] = mk(65535, 0, 65535, 0, 65535, 0, 65535, 0, 2'd0, 131071, 65535, 4);
    tbl[3] = mk(0, 65535, 1, 0, 0, 0, 3, 3, 2'd2, 65536, 65535, 2);

    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("idle");

    for (int i = 0; i < 4; i++) begin
      run_window($sformatf("table%0d", i), tbl[i]);
    end

    // Reset in the middle of a window after two accepts.
    bus.start = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.approx_in = 16'd100;
    bus.exact_in  = 16'd1;
    step();
    bus.approx_in = 16'd2;
    bus.exact_in  = 16'd50;
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    check_all_zero("midreset");
    rst = 1'b0;
    step();
    check_all_zero("after reset");
    run_window("post-reset", mk(7, 3, 7, 3, 7, 3, 7, 3, 2'd0, 16, 4, 4));

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < WIN_LEN; k++) begin
        rv.a[k] = 16'($urandom_range(0, 65535));
        case ($urandom_range(0, 3))
          0:       rv.e[k] = rv.a[k];
          1:       rv.e[k] = 16'($urandom_range(0, 31));
          default: rv.e[k] = 16'($urandom_range(0, 65535));
        endcase
      end
      rv.mode = 2'($urandom_range(0, 2));
      model(rv, es, em, emis, esq);
      rv.exp_sum = 32'(es);
      rv.exp_max = 16'(em);
      rv.exp_mis = 16'(emis);
      run_window($sformatf("random%0d", i), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
